ntt_stage_sequencer: RTL and testbench

- Control FSM sitting directly upstream of the butterfly write-back shuffler.
- Sweeps every NTT stage: issues polynomial-RAM read addresses and a ping-pong bank select for each stage.
- Produces, aligned to the butterfly array's output, the shuffler control bundle: valid, bf_rd_addr, ident_store, dest_rom_gap.
- Inserts a drain gap between stages so that the last write of stage s lands before the first read of stage s+1.

---
 rtl/ntt_ctrl_pkg.sv | 43 ++++
 rtl/ntt_stage_sequencer_if.sv | 42 ++++
 rtl/delay_line.sv | 41 ++++
 rtl/ntt_stage_sequencer.sv | 129 ++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_ctrl_pkg
// Purpose  : Shared NTT control types, sizing helpers and per-stage gap rule.
// Revision : 1.0
// ============================================================================
package ntt_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   function automatic int calc_a(input int logn, input int pe);
      return (1 << logn) / 2 / pe;
   endfunction

   // The extra 3 cycles cover the downstream shuffler latency.
   function automatic int calc_d(input int rd_lat, input int bf_lat);
      return rd_lat + bf_lat + 3;
   endfunction

   function automatic int calc_l(input int rd_lat, input int bf_lat);
      return rd_lat + bf_lat;
   endfunction

   function automatic int calc_aw(input int logn, input int pe);
      return $clog2(calc_a(logn, pe));
   endfunction

   function automatic int stage_gap(input int stage, input int logn, input int logpe);
      int k;
      k = logn - 1 - logpe;
      if (stage < k + 1) begin
         return 1;
      end
      return 1 << (stage - k);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sequencer_if
// Purpose  : Start/status, RAM read and shuffler control bundle of the sequencer.
// Revision : 1.0
// ============================================================================
interface ntt_stage_sequencer_if #(
   parameter int LOGN = 4,
   parameter int PE   = 2
);
   import ntt_ctrl_pkg::*;

   localparam int AW = calc_aw(LOGN, PE);
   localparam int SW = $clog2(LOGN);
   localparam int GW = $clog2(PE) + 1;

   logic          start;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_bank;
   logic [SW-1:0] stage;
   logic          bf_valid;
   logic [AW-1:0] bf_rd_addr;
   logic          ident_store;
   logic [GW-1:0] dest_rom_gap;

   modport master (
      input  start,
      output busy, done, rd_en, rd_addr, rd_bank, stage,
      output bf_valid, bf_rd_addr, ident_store, dest_rom_gap
   );

   modport slave (
      output start,
      input  busy, done, rd_en, rd_addr, rd_bank, stage,
      input  bf_valid, bf_rd_addr, ident_store, dest_rom_gap
   );

endinterface
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module   : delay_line
// Purpose  : Generic DELAY-stage register pipeline, fully cleared on reset.
// Revision : 1.0
// ============================================================================
module delay_line #(
   parameter int DELAY = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (DELAY == 0) begin : g_bypass
         assign o_data = i_data;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_pipe [DELAY];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DELAY; i++) begin
                  r_pipe[i] <= '0;
               end
            end else begin
               r_pipe[0] <= i_data;
               for (int i = 1; i < DELAY; i++) begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end

         assign o_data = r_pipe[DELAY-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sequencer
// Purpose  : Sweeps all NTT stages, issues RAM reads and emits the shuffler
//            control bundle aligned to the butterfly array output.
// Revision : 1.0
// ============================================================================
module ntt_stage_sequencer
   import ntt_ctrl_pkg::*;
#(
   parameter int LOGN   = 4,
   parameter int PE     = 2,
   parameter int RD_LAT = 2,
   parameter int BF_LAT = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ntt_stage_sequencer_if.master bus
);

   localparam int A_CNT = calc_a(LOGN, PE);
   localparam int D_CNT = calc_d(RD_LAT, BF_LAT);
   localparam int L_DLY = calc_l(RD_LAT, BF_LAT);
   localparam int AW    = calc_aw(LOGN, PE);
   localparam int LOGPE = $clog2(PE);
   localparam int GW    = LOGPE + 1;
   localparam int SW    = $clog2(LOGN);
   localparam int DW    = $clog2(D_CNT + 1);
   localparam int BW    = 1 + AW + 1 + GW;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_addr;
   logic [AW-1:0]   w_addr_nxt;
   logic [SW-1:0]   r_stage;
   logic [SW-1:0]   w_stage_nxt;
   logic [DW-1:0]   r_drain;
   logic [DW-1:0]   w_drain_nxt;

   logic            w_rd_en;
   logic            w_ident;
   logic [GW-1:0]   w_gap;
   logic [BW-1:0]   w_dl_in;
   logic [BW-1:0]   w_dl_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_stage <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_stage <= w_stage_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_stage_nxt = r_stage;
      w_drain_nxt = r_drain;
      w_rd_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_RUN;
               w_addr_nxt  = '0;
               w_stage_nxt = '0;
            end
         end
         ST_RUN: begin
            w_rd_en    = 1'b1;
            // A is a power of two, so the increment wraps to 0 on the last address.
            w_addr_nxt = r_addr + AW'(1);
            if (r_addr == AW'(A_CNT - 1)) begin
               w_drain_nxt = '0;
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_drain_nxt = r_drain + DW'(1);
            if (r_drain == DW'(D_CNT - 1)) begin
               if (r_stage == SW'(LOGN - 1)) begin
                  w_state_nxt = ST_FIN;
               end else begin
                  w_stage_nxt = r_stage + SW'(1);
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_FIN: begin
            w_state_nxt = ST_IDLE;
            w_stage_nxt = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Stage controls are zeroed outside RUN so the delayed bundle is clean when invalid.
   assign w_ident = w_rd_en && (r_stage == SW'(LOGN - 1));
   assign w_gap   = w_rd_en ? GW'(stage_gap(int'(r_stage), LOGN, LOGPE)) : '0;
   assign w_dl_in = {w_rd_en, (w_rd_en ? r_addr : '0), w_ident, w_gap};

   delay_line #(
      .DELAY (L_DLY),
      .WIDTH (BW)
   ) u_ctrl_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (w_dl_in),
      .o_data (w_dl_out)
   );

   assign bus.busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign bus.done    = (r_state == ST_FIN);
   assign bus.rd_en   = w_rd_en;
   assign bus.rd_addr = w_rd_en ? r_addr : '0;
   assign bus.rd_bank = r_stage[0];
   assign bus.stage   = r_stage;

   assign {bus.bf_valid, bus.bf_rd_addr, bus.ident_store, bus.dest_rom_gap} = w_dl_out;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_stage_sequencer
// Purpose  : Scoreboard bench for two sequencer configurations.
// Revision : 1.0
// ============================================================================
module tb_ntt_stage_sequencer;

   typedef struct {
      int cyc;
      int addr;
      int bank;
      int stage;
      int gap;
      int ident;
   } exp_t;

   typedef struct {
      int busy;
      int done;
      int rd_en;
      int rd_addr;
      int rd_bank;
      int stage;
      int bf_valid;
      int bf_addr;
      int ident;
      int gap;
   } obs_t;

   localparam int P_A    [2] = '{4, 8};
   localparam int P_D    [2] = '{10, 7};
   localparam int P_L    [2] = '{7, 4};
   localparam int P_LOGN [2] = '{4, 6};
   localparam int GAP_A  [4] = '{1, 1, 1, 2};
   localparam int GAP_B  [6] = '{1, 1, 1, 1, 2, 4};
   localparam string NM  [2] = '{"A", "B"};

   logic clk = 1'b0;
   logic rst_n_a;
   logic rst_n_b;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   st_seen [2] = '{0, 0};
   int   active [2] = '{0, 0};
   int   done_cyc [2] = '{0, 0};
   int   last_done [2] = '{-10, -10};
   int   n_done [2] = '{0, 0};
   exp_t q_rd [2][$];
   exp_t q_bf [2][$];

   always #5 clk = ~clk;

   ntt_stage_sequencer_if #(.LOGN(4), .PE(2)) ifa ();
   ntt_stage_sequencer_if #(.LOGN(6), .PE(4)) ifb ();

   ntt_stage_sequencer #(.LOGN(4), .PE(2), .RD_LAT(2), .BF_LAT(5)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n_a),
      .bus   (ifa)
   );

   ntt_stage_sequencer #(.LOGN(6), .PE(4), .RD_LAT(1), .BF_LAT(3)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (ifb)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int exp_gap(input int i, input int s);
      if (i == 0) return GAP_A[s];
      return GAP_B[s];
   endfunction

   function automatic obs_t snap(input int i);
      obs_t o;
      if (i == 0) begin
         o.busy = int'(ifa.busy);         o.done = int'(ifa.done);
         o.rd_en = int'(ifa.rd_en);       o.rd_addr = int'(ifa.rd_addr);
         o.rd_bank = int'(ifa.rd_bank);   o.stage = int'(ifa.stage);
         o.bf_valid = int'(ifa.bf_valid); o.bf_addr = int'(ifa.bf_rd_addr);
         o.ident = int'(ifa.ident_store); o.gap = int'(ifa.dest_rom_gap);
      end else begin
         o.busy = int'(ifb.busy);         o.done = int'(ifb.done);
         o.rd_en = int'(ifb.rd_en);       o.rd_addr = int'(ifb.rd_addr);
         o.rd_bank = int'(ifb.rd_bank);   o.stage = int'(ifb.stage);
         o.bf_valid = int'(ifb.bf_valid); o.bf_addr = int'(ifb.bf_rd_addr);
         o.ident = int'(ifb.ident_store); o.gap = int'(ifb.dest_rom_gap);
      end
      return o;
   endfunction

   function automatic int any_set(input obs_t o);
      return o.busy | o.done | o.rd_en | o.rd_addr | o.rd_bank | o.stage |
             o.bf_valid | o.bf_addr | o.ident | o.gap;
   endfunction

   // Expected run: stage s reads start at T+1+s*(A+D); outputs trail reads by L.
   task automatic model_start(input int i, input int t);
      exp_t e;
      for (int s = 0; s < P_LOGN[i]; s++) begin
         for (int a = 0; a < P_A[i]; a++) begin
            e.cyc   = t + 1 + s * (P_A[i] + P_D[i]) + a;
            e.addr  = a;
            e.bank  = s % 2;
            e.stage = s;
            e.gap   = exp_gap(i, s);
            e.ident = (s == P_LOGN[i] - 1) ? 1 : 0;
            q_rd[i].push_back(e);
            e.cyc = e.cyc + P_L[i];
            q_bf[i].push_back(e);
         end
      end
      done_cyc[i] = t + 1 + P_LOGN[i] * (P_A[i] + P_D[i]);
      active[i]   = 1;
   endtask

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      st_seen[0] <= int'(ifa.start & rst_n_a);
      st_seen[1] <= int'(ifb.start & rst_n_b);
   end

   always @(negedge clk) begin
      obs_t ob;
      for (int i = 0; i < 2; i++) begin
         int exp_rd;
         int exp_bf;
         int exp_busy;
         int exp_done;
         ob = snap(i);
         if ((st_seen[i] != 0) && (active[i] == 0) && (cyc - 1 > last_done[i])) begin
            model_start(i, cyc - 1);
         end
         exp_rd = (q_rd[i].size() > 0 && q_rd[i][0].cyc == cyc) ? 1 : 0;
         chk({NM[i], ".rd_en"}, ob.rd_en, exp_rd);
         if (exp_rd != 0) begin
            chk({NM[i], ".rd_addr"}, ob.rd_addr, q_rd[i][0].addr);
            chk({NM[i], ".rd_bank"}, ob.rd_bank, q_rd[i][0].bank);
            chk({NM[i], ".stage"}, ob.stage, q_rd[i][0].stage);
            void'(q_rd[i].pop_front());
         end
         exp_bf = (q_bf[i].size() > 0 && q_bf[i][0].cyc == cyc) ? 1 : 0;
         chk({NM[i], ".bf_valid"}, ob.bf_valid, exp_bf);
         if (exp_bf != 0) begin
            chk({NM[i], ".bf_rd_addr"}, ob.bf_addr, q_bf[i][0].addr);
            chk({NM[i], ".dest_rom_gap"}, ob.gap, q_bf[i][0].gap);
            chk({NM[i], ".ident_store"}, ob.ident, q_bf[i][0].ident);
            void'(q_bf[i].pop_front());
         end else begin
            chk({NM[i], ".bf_ctrl_idle"}, ob.bf_addr | ob.gap | ob.ident, 0);
         end
         exp_busy = (active[i] != 0 && cyc < done_cyc[i]) ? 1 : 0;
         exp_done = (active[i] != 0 && cyc == done_cyc[i]) ? 1 : 0;
         chk({NM[i], ".busy"}, ob.busy, exp_busy);
         chk({NM[i], ".done"}, ob.done, exp_done);
         if (ob.done != 0) n_done[i]++;
         if (exp_done != 0) begin
            active[i]    = 0;
            last_done[i] = cyc;
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Start is sampled by the posedge whose cycle count becomes e.
   task automatic pulse_start(input logic a, input logic b, input int e);
      wait_cyc(e - 1);
      ifa.start = a;
      ifb.start = b;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input int i, input int bound);
      int n;
      n = 0;
      while (active[i] != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk({NM[i], ".finished_in_time"}, active[i], 0);
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int t1;
      rst_n_a   = 1'b0;
      rst_n_b   = 1'b0;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("A.reset_outputs", any_set(snap(0)), 0);
      chk("B.reset_outputs", any_set(snap(1)), 0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // Both configurations run; A also sees ignored starts mid-run and at FIN.
      pulse_start(1'b1, 1'b1, cyc + 1);
      t0 = cyc - 1;
      chk("A.accepted", active[0], 1);
      chk("B.accepted", active[1], 1);
      pulse_start(1'b1, 1'b0, t0 + 21);
      pulse_start(1'b1, 1'b0, t0 + 58);
      chk("A.done_count_first", n_done[0], 1);
      chk("A.fin_start_ignored", active[0], 0);
      pulse_start(1'b1, 1'b0, t0 + 59);
      chk("A.restart_accepted", active[0], 1);
      wait_idle(0, 400);
      wait_idle(1, 400);
      chk("A.done_count_two_runs", n_done[0], 2);
      chk("B.done_count", n_done[1], 1);

      // Asynchronous reset while stage 0 is draining.
      pulse_start(1'b1, 1'b0, cyc + 1);
      t1 = cyc - 1;
      wait_cyc(t1 + 10);
      #2;
      chk("A.in_drain_before_reset", snap(0).busy, 1);
      rst_n_a = 1'b0;
      #1;
      chk("A.outputs_zero_in_reset", any_set(snap(0)), 0);
      q_rd[0].delete();
      q_bf[0].delete();
      active[0] = 0;
      repeat (3) @(negedge clk);
      #2;
      rst_n_a = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("A.done_count_after_reset", n_done[0], 2);

      pulse_start(1'b1, 1'b0, cyc + 1);
      wait_idle(0, 400);
      chk("A.done_count_clean_run", n_done[0], 3);

      for (int i = 0; i < 2; i++) begin
         chk({NM[i], ".rd_queue_drained"}, q_rd[i].size(), 0);
         chk({NM[i], ".bf_queue_drained"}, q_bf[i].size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
